shift_unit_sequencer: RTL and testbench

Controller that time-shares the FP add/sub two-stage barrel shifter (`Mux_Array`, one internal mid-register) between two requesters:

- **Exponent-alignment** path: right shift.
- **Post-add normalization** path: left shift.

The block arbitrates requests, registers operands, drives the shifter's load/select/shift inputs, and captures the shifter output into a result register. It reports completion with a source tag. It sits between the FPU add/sub FSM datapath and the shifter instance in the parent.

---
 rtl/fpu_shift_pkg.sv | 9 +
 rtl/shift_rr_arbiter.sv | 24 ++
 rtl/shift_unit_sequencer.sv | 90 +++++++++
 tb/tb_shift_unit_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_shift_pkg.sv
// fpu_shift_pkg: shared encodings for the FP add/sub shifter sequencer
// Holds the sequencer state encoding, requester source tags and shift directions.
package fpu_shift_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;
   localparam logic SRC_ALIGN = 1'b0;
   localparam logic SRC_NORM  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/shift_rr_arbiter.sv
// shift_rr_arbiter: 2-way round-robin grant between alignment and normalization
// Ports: clk, rst; en (grant allowed this cycle); align_req, norm_req;
//        grant (a request was granted), src (granted source, SRC_ALIGN/SRC_NORM).
module shift_rr_arbiter
   import fpu_shift_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic align_req,
   input  logic norm_req,
   output logic grant,
   output logic src
);
   logic last_src;
   // On conflict the source that did not win last time is chosen;
   // last_src resets to norm so the first conflict goes to align.
   assign src   = (align_req & norm_req) ? ~last_src : (norm_req ? SRC_NORM : SRC_ALIGN);
   assign grant = en & (align_req | norm_req);
   always_ff @(posedge clk) begin
      if (rst) last_src <= SRC_NORM;
      else if (grant) last_src <= src;
   end
endmodule

// File: rtl/shift_unit_sequencer.sv
// shift_unit_sequencer: time-shares the two-stage barrel shifter between align and norm
// Ports: align_*/norm_* request/operand/ack per requester; flush_i aborts the
//        in-flight op; shf_* drive and observe the shifter; result_o/done_o/
//        done_src_o report a completed shift; busy_o and sticky err_o status.
module shift_unit_sequencer
   import fpu_shift_pkg::*;
#(
   parameter int SWR = 26,
   parameter int EWR = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           align_req_i,
   input  logic [SWR-1:0] align_data_i,
   input  logic [EWR-1:0] align_shamt_i,
   input  logic           align_fill_i,
   output logic           align_ack_o,
   input  logic           norm_req_i,
   input  logic [SWR-1:0] norm_data_i,
   input  logic [EWR-1:0] norm_shamt_i,
   input  logic           norm_fill_i,
   output logic           norm_ack_o,
   input  logic           flush_i,
   output logic [SWR-1:0] shf_data_o,
   output logic           shf_left_right_o,
   output logic [EWR-1:0] shf_shamt_o,
   output logic           shf_bit_shift_o,
   output logic           shf_load_o,
   input  logic [SWR-1:0] shf_data_i,
   input  logic           shf_load_i,
   output logic [SWR-1:0] result_o,
   output logic           done_o,
   output logic           done_src_o,
   output logic           busy_o,
   output logic           err_o
);
   state_t state, state_nx;
   logic grant, src, cur_src, capture_ok, capture_err;
   shift_rr_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (state == ST_IDLE && !flush_i),
      .align_req (align_req_i),
      .norm_req  (norm_req_i),
      .grant     (grant),
      .src       (src)
   );
   always_comb begin
      state_nx    = state == ST_IDLE  ? (grant ? ST_ISSUE : ST_IDLE)
                  : state == ST_ISSUE ? (flush_i ? ST_IDLE : ST_CAPTURE)
                  : ST_IDLE;
      capture_ok  = state == ST_CAPTURE && !flush_i && shf_load_i;
      capture_err = state == ST_CAPTURE && !flush_i && !shf_load_i;
      align_ack_o = grant && src == SRC_ALIGN;
      norm_ack_o  = grant && src == SRC_NORM;
      shf_load_o  = state == ST_ISSUE;
      busy_o      = state != ST_IDLE;
   end
   // Operand registers are the only source of shf_* so requester inputs never
   // reach the shifter combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         shf_data_o       <= '0;
         shf_shamt_o      <= '0;
         shf_bit_shift_o  <= 1'b0;
         shf_left_right_o <= DIR_RIGHT;
         cur_src          <= SRC_ALIGN;
         result_o         <= '0;
         done_o           <= 1'b0;
         done_src_o       <= SRC_ALIGN;
         err_o            <= 1'b0;
      end else begin
         state  <= state_nx;
         done_o <= capture_ok;
         if (grant) begin
            shf_data_o       <= src == SRC_NORM ? norm_data_i : align_data_i;
            shf_shamt_o      <= src == SRC_NORM ? norm_shamt_i : align_shamt_i;
            shf_bit_shift_o  <= src == SRC_NORM ? norm_fill_i : align_fill_i;
            shf_left_right_o <= src == SRC_NORM ? DIR_LEFT : DIR_RIGHT;
            cur_src          <= src;
         end
         if (capture_ok) begin
            result_o   <= shf_data_i;
            done_src_o <= cur_src;
         end
         if (capture_err) err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_shift_unit_sequencer.sv
// tb_shift_unit_sequencer: randomized and directed check against a cycle-level reference model
module tb_shift_unit_sequencer;
   localparam int SWR = 26;
   localparam int EWR = 5;
   logic clk = 0, rst = 1;
   logic align_req_i = 0, align_fill_i = 0, norm_req_i = 0, norm_fill_i = 0, flush_i = 0;
   logic [SWR-1:0] align_data_i = '0, norm_data_i = '0;
   logic [EWR-1:0] align_shamt_i = '0, norm_shamt_i = '0;
   logic align_ack_o, norm_ack_o, shf_left_right_o, shf_bit_shift_o, shf_load_o;
   logic [SWR-1:0] shf_data_o, shf_data_i, result_o;
   logic [EWR-1:0] shf_shamt_o;
   logic shf_load_i, done_o, done_src_o, busy_o, err_o;
   logic kill = 0, ld;
   logic [SWR-1:0] mid;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   shift_unit_sequencer #(.SWR(SWR), .EWR(EWR)) dut (
      .clk(clk), .rst(rst),
      .align_req_i(align_req_i), .align_data_i(align_data_i), .align_shamt_i(align_shamt_i),
      .align_fill_i(align_fill_i), .align_ack_o(align_ack_o),
      .norm_req_i(norm_req_i), .norm_data_i(norm_data_i), .norm_shamt_i(norm_shamt_i),
      .norm_fill_i(norm_fill_i), .norm_ack_o(norm_ack_o),
      .flush_i(flush_i),
      .shf_data_o(shf_data_o), .shf_left_right_o(shf_left_right_o), .shf_shamt_o(shf_shamt_o),
      .shf_bit_shift_o(shf_bit_shift_o), .shf_load_o(shf_load_o),
      .shf_data_i(shf_data_i), .shf_load_i(shf_load_i),
      .result_o(result_o), .done_o(done_o), .done_src_o(done_src_o),
      .busy_o(busy_o), .err_o(err_o)
   );
   // Shifter stand-in: level-by-level barrel shift into one mid-register.
   function automatic logic [SWR-1:0] barrel(logic [SWR-1:0] d, logic [EWR-1:0] a, logic f, logic left);
      logic [SWR-1:0] x = d;
      for (int k = 0; k < EWR; k++)
         if (a[k])
            for (int j = 0; j < (1 << k); j++)
               x = left ? {x[SWR-2:0], f} : {f, x[SWR-1:1]};
      return x;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         ld  <= 1'b0;
         mid <= '0;
      end else begin
         ld <= shf_load_o;
         if (shf_load_o) mid <= barrel(shf_data_o, shf_shamt_o, shf_bit_shift_o, shf_left_right_o);
      end
   end
   assign shf_data_i = mid;
   assign shf_load_i = ld & ~kill;
   // Expected shift result from plain arithmetic.
   function automatic logic [SWR-1:0] ref_shift(logic [SWR-1:0] d, logic [EWR-1:0] a, logic f, logic left);
      logic [63:0] m, r;
      m = (64'd1 << SWR) - 1;
      if (left) r = ((64'(d) << a) | (f ? (64'd1 << a) - 1 : 64'd0)) & m;
      else r = (64'(d) >> a) | (f ? (m & ~(m >> a)) : 64'd0);
      return r[SWR-1:0];
   endfunction
   task automatic chk(input string tag, input logic [SWR-1:0] got, input logic [SWR-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Reference model: absolute-cycle bookkeeping of when the unit is free,
   // which op completes when, and round-robin memory of the last winner.
   int cyc = 0, free_at = 0, pend_t = 0, issue_t = -1;
   logic pend_v = 0, pend_src = 0, m_last = 1, m_err = 0, m_src = 0;
   logic [SWR-1:0] pend_res = '0, m_result = '0, i_data = '0;
   logic [EWR-1:0] i_shamt = '0;
   logic i_fill = 0, i_dir = 0;
   logic [7:0] ack_log = '0;
   task automatic step(input logic ar, input logic [SWR-1:0] ad, input logic [EWR-1:0] as, input logic af,
                       input logic nr, input logic [SWR-1:0] nd, input logic [EWR-1:0] ns, input logic nf,
                       input logic fl, input logic kl);
      logic idle, e_done, s, e_aa, e_na;
      @(negedge clk);
      align_req_i = ar; align_data_i = ad; align_shamt_i = as; align_fill_i = af;
      norm_req_i = nr; norm_data_i = nd; norm_shamt_i = ns; norm_fill_i = nf;
      flush_i = fl; kill = kl;
      #1;
      idle = cyc >= free_at;
      e_done = pend_v && pend_t == cyc;
      if (e_done) begin
         m_result = pend_res;
         m_src = pend_src;
         pend_v = 0;
      end
      chk("done", SWR'(done_o), SWR'(e_done));
      chk("result", result_o, m_result);
      if (e_done) chk("done_src", SWR'(done_src_o), SWR'(m_src));
      chk("busy", SWR'(busy_o), SWR'(!idle));
      chk("err", SWR'(err_o), SWR'(m_err));
      chk("shf_load", SWR'(shf_load_o), SWR'(cyc == issue_t));
      if (cyc == issue_t) begin
         chk("shf_dir", SWR'(shf_left_right_o), SWR'(i_dir));
         chk("shf_data", shf_data_o, i_data);
         chk("shf_shamt", SWR'(shf_shamt_o), SWR'(i_shamt));
         chk("shf_fill", SWR'(shf_bit_shift_o), SWR'(i_fill));
      end
      e_aa = 0;
      e_na = 0;
      if (idle && !fl && (ar || nr)) begin
         s = (ar && nr) ? ~m_last : nr;
         m_last = s;
         e_aa = !s;
         e_na = s;
         pend_v = 1;
         pend_t = cyc + 3;
         pend_src = s;
         pend_res = s ? ref_shift(nd, ns, nf, 1) : ref_shift(ad, as, af, 0);
         issue_t = cyc + 1;
         i_data = s ? nd : ad;
         i_shamt = s ? ns : as;
         i_fill = s ? nf : af;
         i_dir = s;
         free_at = cyc + 3;
      end else if (!idle && fl) begin
         pend_v = 0;
         free_at = cyc + 1;
      end else if (!idle && kl && pend_v && cyc == pend_t - 1) begin
         m_err = 1;
         pend_v = 0;
      end
      chk("align_ack", SWR'(align_ack_o), SWR'(e_aa));
      chk("norm_ack", SWR'(norm_ack_o), SWR'(e_na));
      if (align_ack_o || norm_ack_o) ack_log = {ack_log[6:0], norm_ack_o};
      cyc++;
   endtask
   task automatic idle_step(input logic fl, input logic kl);
      step(0, '0, '0, 0, 0, '0, '0, 0, fl, kl);
   endtask
   task automatic do_reset;
      @(negedge clk);
      rst = 1;
      align_req_i = 0; norm_req_i = 0; flush_i = 0; kill = 0;
      @(negedge clk);
      #1;
      chk("rst_result", result_o, '0);
      chk("rst_flags", SWR'({done_o, done_src_o, align_ack_o, norm_ack_o, busy_o, err_o}), '0);
      chk("rst_shf", SWR'({shf_load_o, shf_left_right_o, shf_bit_shift_o, shf_shamt_o}), '0);
      chk("rst_shf_data", shf_data_o, '0);
      rst = 0;
      cyc++;
      free_at = cyc; pend_v = 0; issue_t = -1; m_last = 1; m_err = 0; m_result = '0;
   endtask
   initial begin
      do_reset();
      // single align
      step(1, 26'h3FF0000, 5'd4, 0, 0, '0, '0, 0, 0, 0);
      repeat (3) idle_step(0, 0);
      chk("t1_result", result_o, 26'h03FF000);
      // single norm
      step(0, '0, '0, 0, 1, 26'h0000123, 5'd8, 0, 0, 0);
      repeat (3) idle_step(0, 0);
      chk("t2_result", result_o, 26'h0012300);
      // simultaneous requests: fresh operand every cycle, both held
      do_reset();
      for (int i = 0; i < 9; i++)
         step(1, SWR'($urandom), EWR'($urandom), 0, 1, SWR'($urandom), EWR'($urandom), 1, 0, 0);
      chk("t3_order", SWR'(ack_log[2:0]), SWR'(3'b010));
      repeat (3) idle_step(0, 0);
      // flush in CAPTURE of an align op, norm waiting
      step(1, 26'h155AAAA, 5'd3, 1, 0, '0, '0, 0, 0, 0);
      step(0, '0, '0, 0, 1, 26'h0000F0F, 5'd2, 0, 0, 0);
      step(0, '0, '0, 0, 1, 26'h0000F0F, 5'd2, 0, 1, 0);
      step(0, '0, '0, 0, 1, 26'h0000F0F, 5'd2, 0, 0, 0);
      chk("t4_ack_after_flush", SWR'(norm_ack_o), SWR'(1));
      repeat (3) idle_step(0, 0);
      // protocol error
      step(1, 26'h0ABCDEF, 5'd1, 0, 0, '0, '0, 0, 0, 0);
      idle_step(0, 0);
      idle_step(0, 1);
      repeat (3) idle_step(0, 0);
      chk("t5_err_sticky", SWR'(err_o), SWR'(1));
      do_reset();
      // overshift
      step(1, 26'h0000001, 5'd31, 1, 0, '0, '0, 0, 0, 0);
      repeat (3) idle_step(0, 0);
      chk("t6_overshift", result_o, 26'h3FFFFFF);
      // random traffic with occasional flushes
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 2) != 0, SWR'($urandom), EWR'($urandom), 1'($urandom),
              $urandom_range(0, 2) != 0, SWR'($urandom), EWR'($urandom), 1'($urandom),
              $urandom_range(0, 15) == 0, 0);
      repeat (4) idle_step(0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
